// File: rtl/axi4_read_responder_if.sv
// AXI4 read-channel bundle (AR + R) between the instruction cache and its refill memory.
interface axi4_read_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   ar_id;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [ID_WIDTH-1:0]   r_id;
   logic [31:0]           r_data;
   logic [1:0]            r_resp;
   logic                  r_last;
   logic                  r_valid;
   logic                  r_ready;

   modport master (
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_valid,
      output r_ready
   );

   modport slave (
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/axi4_read_responder.sv
// AXI4 read slave serving burst refills from a word-addressed on-chip SRAM,
// with a backdoor load port for filling the SRAM.
module axi4_read_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    MEM_DEPTH  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1C00_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   axi4_read_responder_if.slave         bus,
   input  logic                         ld_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
   input  logic [31:0]                  ld_wdata
);
   localparam int                    IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH) << 2;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state, state_next;
   logic [31:0]           mem [MEM_DEPTH];

   // Latched burst context; cur_addr is the address of the beat currently on R.
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]            lat_len;
   logic [1:0]            lat_burst;
   logic                  req_err;
   logic [7:0]            beat_cnt;

   logic                  ar_hs;
   logic                  advance;
   logic                  rd_en;
   logic                  new_req_err;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] rd_offset;
   logic [IDX_W-1:0]      rd_index;
   logic                  beat_err;
   logic                  rd_is_last;

   assign bus.ar_ready = (state == IDLE);
   assign ar_hs        = bus.ar_valid & bus.ar_ready;
   assign advance      = (state == BURST) & bus.r_valid & bus.r_ready & ~bus.r_last;
   assign rd_en        = ar_hs | advance;

   // Only SINGLE-word beats and legal WRAP lengths are served; anything else errors every beat.
   assign new_req_err = (bus.ar_size != 3'b010) | (bus.ar_burst == 2'b11) |
                        ((bus.ar_burst == 2'b10) &
                         !(bus.ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

   // (len+1)*4-1 is simply len with two low ones appended.
   assign wrap_mask = ADDR_WIDTH'({lat_len, 2'b11});

   // Address of the beat that follows the one currently presented.
   always_comb begin
      next_addr = cur_addr + ADDR_WIDTH'(4);
      case (lat_burst)
         2'b00:   next_addr = cur_addr;
         2'b10:   next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + ADDR_WIDTH'(4)) & wrap_mask);
         default: next_addr = cur_addr + ADDR_WIDTH'(4);
      endcase
   end

   // Beat 0 is fetched straight from ar_addr so the first beat comes out one cycle after AR.
   assign rd_addr    = ar_hs ? bus.ar_addr : next_addr;
   assign rd_offset  = rd_addr - BASE_ADDR;
   assign rd_index   = rd_offset[IDX_W+1:2];
   assign beat_err   = (ar_hs ? new_req_err : req_err) | (rd_offset >= MEM_BYTES);
   assign rd_is_last = ar_hs ? (bus.ar_len == 8'd0) : ((beat_cnt + 8'd1) == lat_len);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Accept a request in IDLE; leave BURST once the last beat has been taken.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ar_hs) state_next = BURST;
         BURST:   if (bus.r_valid & bus.r_ready & bus.r_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Backdoor writes; they land via NBA so a same-edge AXI read sees the old word.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_wdata;
   end

   // Burst context and the registered R channel, advanced only when a new beat is read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr    <= '0;
         lat_len     <= '0;
         lat_burst   <= '0;
         req_err     <= 1'b0;
         beat_cnt    <= '0;
         bus.r_id    <= '0;
         bus.r_valid <= 1'b0;
         bus.r_last  <= 1'b0;
         bus.r_resp  <= 2'b00;
         bus.r_data  <= '0;
      end else begin
         if (ar_hs) begin
            cur_addr  <= bus.ar_addr;
            lat_len   <= bus.ar_len;
            lat_burst <= bus.ar_burst;
            req_err   <= new_req_err;
            beat_cnt  <= 8'd0;
            bus.r_id  <= bus.ar_id;
         end else if (advance) begin
            cur_addr <= next_addr;
            beat_cnt <= beat_cnt + 8'd1;
         end

         if (ar_hs)
            bus.r_valid <= 1'b1;
         else if (bus.r_valid & bus.r_ready & bus.r_last)
            bus.r_valid <= 1'b0;

         if (rd_en) begin
            bus.r_last <= rd_is_last;
            bus.r_resp <= beat_err ? 2'b10 : 2'b00;
            bus.r_data <= beat_err ? 32'h0 : mem[rd_index];
         end
      end
   end
endmodule
